// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage feeding decode.
//
// Fetches one 32-bit instruction as four little-endian byte beats over an
// 8-bit memory port, then presents it downstream until it is consumed.
// A branch/jump redirect from execute takes priority over everything and
// aborts any fetch in flight.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   stall_i          downstream not ready; hold presented instruction
//   branch_flag_i    redirect request (one-cycle pulse)
//   branch_target_i  redirect target PC (low two bits ignored)
//   mem_req_o        byte read request
//   mem_addr_o       byte address of the current beat
//   mem_rdata_i      read byte, valid with mem_ack_i
//   mem_ack_i        beat complete (may arrive in the cycle req rises)
//   pc_o             PC of the presented instruction
//   inst_o           presented instruction (NOP_INST while not valid)
//   inst_valid_o     pc_o/inst_o valid
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {
    ST_B0   = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  // Byte offset of the beat fetched in a given state (HOLD has no beat).
  function automatic logic [1:0] beat_off(input state_t st);
    case (st)
      ST_B1:   beat_off = 2'd1;
      ST_B2:   beat_off = 2'd2;
      ST_B3:   beat_off = 2'd3;
      default: beat_off = 2'd0;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [23:0] buf_r, buf_s;
  logic [31:0] pc_out_r, pc_out_s;
  logic [31:0] inst_r, inst_s;
  logic        valid_r, valid_s;
  logic        req_r, req_s;
  logic [31:0] addr_r, addr_s;
  logic        beat_done_s;

  // An ack only counts while a request is actually being presented.
  assign beat_done_s = req_r & mem_ack_i;

  // Next-state, PC, byte buffer and output computation.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    buf_s    = buf_r;
    pc_out_s = pc_out_r;
    inst_s   = inst_r;
    valid_s  = valid_r;

    if (branch_flag_i) begin
      // Redirect wins: drop any beat arriving now and any presented instruction.
      pc_s    = branch_target_i & ~32'h0000_0003;
      state_s = ST_B0;
      valid_s = 1'b0;
      inst_s  = NOP_INST;
    end else begin
      case (state_r)
        ST_B0: begin
          if (beat_done_s) begin
            buf_s[7:0] = mem_rdata_i;
            state_s    = ST_B1;
          end else begin
            state_s = ST_B0;
          end
        end
        ST_B1: begin
          if (beat_done_s) begin
            buf_s[15:8] = mem_rdata_i;
            state_s     = ST_B2;
          end else begin
            state_s = ST_B1;
          end
        end
        ST_B2: begin
          if (beat_done_s) begin
            buf_s[23:16] = mem_rdata_i;
            state_s      = ST_B3;
          end else begin
            state_s = ST_B2;
          end
        end
        ST_B3: begin
          if (beat_done_s) begin
            inst_s   = {mem_rdata_i, buf_r};
            pc_out_s = pc_r;
            valid_s  = 1'b1;
            state_s  = ST_HOLD;
          end else begin
            state_s = ST_B3;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            pc_s    = pc_r + 32'd4;
            valid_s = 1'b0;
            inst_s  = NOP_INST;
            state_s = ST_B0;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s = ST_B0;
        end
      endcase
    end
  end

  // Memory request/address are registered from the next state so they never
  // depend combinationally on inputs.
  always_comb begin
    req_s  = (state_s != ST_HOLD);
    addr_s = pc_s + {30'd0, beat_off(state_s)};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_B0;
      pc_r     <= RESET_PC;
      buf_r    <= 24'd0;
      pc_out_r <= RESET_PC;
      inst_r   <= NOP_INST;
      valid_r  <= 1'b0;
      req_r    <= 1'b0;
      addr_r   <= RESET_PC;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      buf_r    <= buf_s;
      pc_out_r <= pc_out_s;
      inst_r   <= inst_s;
      valid_r  <= valid_s;
      req_r    <= req_s;
      addr_r   <= addr_s;
    end
  end

  assign mem_req_o    = req_r;
  assign mem_addr_o   = addr_r;
  assign pc_o         = pc_out_r;
  assign inst_o       = inst_r;
  assign inst_valid_o = valid_r;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural model (PC + bytes-collected count) checked
// on every falling edge, directed scenarios with literal expectations, then
// randomized redirects, stalls and ack timing.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_rdata_i = 8'd0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_cnt = bytes collected (4 = instruction presented).
  logic        m_active;
  int          m_cnt;
  logic [7:0]  m_bytes [4];
  logic [31:0] m_pc, m_inst, m_pcout;
  logic        m_valid;

  int          ack_mode = 0;   // 0 zero-wait, 1 three wait cycles, 2 random
  int          wcnt = 0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] prog [4];
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h50; prog[3] = 8'h00;
    if (a < 32'd4) return prog[a[1:0]];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_cnt = 0; m_pc = RESET_PC;
    m_inst = NOP_INST; m_pcout = RESET_PC; m_valid = 1'b0;
  endtask

  task automatic model_update();
    if (branch_flag_i) begin
      m_pc = branch_target_i & ~32'h0000_0003;
      m_cnt = 0; m_valid = 1'b0; m_inst = NOP_INST; m_active = 1'b1;
    end else if (!m_active) begin
      m_active = 1'b1;
    end else if (m_cnt < 4) begin
      if (mem_ack_i) begin
        m_bytes[m_cnt] = mem_rdata_i;
        m_cnt++;
        if (m_cnt == 4) begin
          m_inst  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_pcout = m_pc;
          m_valid = 1'b1;
        end
      end
    end else if (!stall_i) begin
      m_pc = m_pc + 32'd4; m_cnt = 0; m_valid = 1'b0; m_inst = NOP_INST;
    end
  endtask

  // One clock: drive inputs for the coming edge, then advance the model.
  task automatic step(input logic r, input logic br, input logic [31:0] tgt, input logic st);
    @(negedge clk); #1;
    rst = r; branch_flag_i = br; branch_target_i = tgt; stall_i = st;
    case (ack_mode)
      0: mem_ack_i = mem_req_o;
      1: begin
        if (mem_req_o && mem_addr_o == last_addr) wcnt++;
        else wcnt = 0;
        last_addr = mem_addr_o;
        mem_ack_i = mem_req_o && (wcnt >= 3);
      end
      default: mem_ack_i = ($urandom_range(0, 2) != 0);
    endcase
    mem_rdata_i = mem_ack_i ? mem_byte(mem_addr_o) : 8'($urandom);
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_update();
    #1;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !inst_valid_o; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wait_valid", {31'd0, inst_valid_o}, 32'd1);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_req;
    exp_req = m_active && (m_cnt < 4);
    chk("valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
    chk("inst", inst_o, m_inst);
    chk("req", {31'd0, mem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("addr", mem_addr_o, m_pc + 32'(m_cnt));
    else if (!m_active) chk("addr_rst", mem_addr_o, RESET_PC);
    if (m_valid || !m_active) chk("pc", pc_o, m_pcout);
  end

  initial begin
    model_reset();
    // Reset held, then test 1: release with zero-wait memory.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t1_req_cycle1", {31'd0, mem_req_o}, 32'd1);
    chk("t1_addr_cycle1", mem_addr_o, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("t1_inst", inst_o, 32'h0050_0513);
    chk("t1_pc", pc_o, 32'd0);

    // Test 3: stall in HOLD, then consume.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t3_hold_inst", inst_o, 32'h0050_0513);
    chk("t3_hold_req", {31'd0, mem_req_o}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("t3_next_addr", mem_addr_o, 32'd4);
    chk("t3_next_req", {31'd0, mem_req_o}, 32'd1);

    // Test 2: same program with three wait cycles per beat.
    ack_mode = 1;
    step(1'b1, 1'b1, 32'd0, 1'b1);
    wait_valid(60);
    chk("t2_inst", inst_o, 32'h0050_0513);
    chk("t2_pc", pc_o, 32'd0);

    // Test 4: redirect during B2 together with an ack.
    ack_mode = 0;
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t4_in_b2", mem_addr_o, 32'd6);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    chk("t4_redirect_addr", mem_addr_o, 32'h0000_0100);
    wait_valid(20);
    chk("t4_pc", pc_o, 32'h0000_0100);

    // Test 5: redirect in HOLD coinciding with a consume.
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    chk("t5_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("t5_inst", inst_o, NOP_INST);
    chk("t5_addr", mem_addr_o, 32'h0000_0200);

    // Test 6: asynchronous reset during B1.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t6_in_b1", mem_addr_o, 32'h0000_0201);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("t6_rst_addr", mem_addr_o, RESET_PC);
    chk("t6_rst_pc", pc_o, RESET_PC);
    chk("t6_rst_inst", inst_o, NOP_INST);
    chk("t6_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t6_restart_addr", mem_addr_o, 32'd0);
    chk("t6_restart_req", {31'd0, mem_req_o}, 32'd1);

    // PC wrap on consume.
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
    wait_valid(20);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("wrap_next_addr", mem_addr_o, 32'd0);

    // Randomized phase: random ack timing, stalls and redirects.
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, ($urandom_range(0, 15) == 0), $urandom, $urandom_range(0, 1) != 0);
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
